// File: rtl/gf8_reduce_acc_if.sv
// Purpose: handshake/bus bundle for gf8_reduce_acc (product beats in, field element out).
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready carry valid-ready flow control in each direction.
//
// Signals:
//   in_valid/in_ready  product beat handshake
//   in_lo[6:0]         product coefficients x^0..x^6
//   in_hi[7:0]         product coefficients x^7..x^14 (bit0 = x^7)
//   in_last            last beat of a frame
//   out_valid/out_ready result handshake
//   out_data[7:0]      reduced (accumulated) field element
//   out_ovf            frame exceeded MAX_BEATS, qualified by out_valid
// Modports: master = producer of beats / consumer of results, slave = the reduce stage.
interface gf8_reduce_acc_if;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_lo;
    logic [7:0] in_hi;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf;

    modport master (
        output in_valid, in_lo, in_hi, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_lo, in_hi, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/gf8_reduce_acc.sv
// Purpose: reduce a 15-coefficient carry-less product modulo POLY, optionally XOR-accumulate per frame.
// Latency: beat captured into S1 on its accept edge, result on out_valid after the next edge; 1 beat/clk.
// Backpressure: only a last beat waits on a held output; in_ready drops once S1 is occupied and stalled.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (all state cleared, in_ready low while asserted)
//   bus    gf8_reduce_acc_if.slave: in_valid/in_ready/in_lo/in_hi/in_last, out_valid/out_ready/out_data/out_ovf
// Build option: define GF8_ACC_EN for frame accumulation (in_last delimits frames, out_ovf flags
// frames longer than MAX_BEATS). Without it every beat is its own result, in_last is ignored and
// out_ovf is constant 0.
module gf8_reduce_acc #(
    parameter logic [8:0] POLY      = 9'h11B,
    parameter int          MAX_BEATS = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    gf8_reduce_acc_if.slave bus
);

    // Elaboration-time sanity on the configuration.
    if (POLY[8] != 1'b1) begin : g_bad_poly
        $error("gf8_reduce_acc: POLY bit 8 must be set");
    end
    if (MAX_BEATS < 1) begin : g_bad_beats
        $error("gf8_reduce_acc: MAX_BEATS must be at least 1");
    end

    // Long division by POLY, top coefficient first, leaving the 8-bit remainder.
    function automatic logic [7:0] gf_reduce(input logic [14:0] prod);
        logic [14:0] p;
        p = prod;
        for (int i = 14; i >= 8; i--) begin
            if (p[i]) begin
                p = p ^ (15'(POLY) << (i - 8));
            end
        end
        return p[7:0];
    endfunction

    logic       ready_en;     // low through reset so nothing is accepted until the first clean edge
    logic       s1_valid;
    logic       s1_last;
    logic [7:0] s1_data;
    logic       out_valid_q;
    logic [7:0] out_data_q;

    logic       beat_last;
    logic       in_rdy;
    logic       in_fire;
    logic       out_fire;
    logic       s1_adv;
    logic [7:0] result;

`ifdef GF8_ACC_EN
    assign beat_last = bus.in_last;
`else
    // Every beat closes its own frame.
    assign beat_last = bus.in_last | 1'b1;
`endif

    // A non-last beat only folds into the accumulator, so it never waits on the output register.
    assign s1_adv   = s1_valid && (!s1_last || !out_valid_q || bus.out_ready);
    assign in_rdy   = ready_en && (!s1_valid || s1_adv);
    assign in_fire  = bus.in_valid && in_rdy;
    assign out_fire = out_valid_q && bus.out_ready;

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // S1: reduced product plus frame-end flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_data  <= 8'h00;
        end else begin
            ready_en <= 1'b1;
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_last  <= beat_last;
                s1_data  <= gf_reduce({bus.in_hi, bus.in_lo});
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

`ifdef GF8_ACC_EN
    localparam int CW = $clog2(MAX_BEATS + 1);

    logic [7:0]    acc;
    logic [CW-1:0] cnt;
    logic [CW:0]   cnt_inc;
    logic          cnt_ovf;
    logic          out_ovf_q;

    // cnt_inc is one bit wider so a saturated count still compares past MAX_BEATS.
    assign cnt_inc = {1'b0, cnt} + (CW + 1)'(1);
    assign cnt_ovf = cnt_inc > (CW + 1)'(MAX_BEATS);
    assign result  = acc ^ s1_data;

    assign bus.out_ovf = out_ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= 8'h00;
            cnt       <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            if (s1_adv) begin
                if (s1_last) begin
                    acc <= 8'h00;
                    cnt <= '0;
                end else begin
                    acc <= result;
                    cnt <= cnt_ovf ? CW'(MAX_BEATS) : cnt_inc[CW-1:0];
                end
            end
            if (s1_adv && s1_last) begin
                out_ovf_q <= cnt_ovf;
            end else if (out_fire) begin
                out_ovf_q <= 1'b0;
            end
        end
    end
`else
    assign result      = s1_data;
    assign bus.out_ovf = 1'b0;
`endif

    // S2: result register. A new frame result may load on the same edge the old one leaves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
        end else begin
            if (s1_adv && s1_last) begin
                out_valid_q <= 1'b1;
                out_data_q  <= result;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule
